// File: rtl/mem_stage_nlane.sv
// N-lane data-memory stage: execute -> writeback, shared word array.
// Two-deep pipeline with interlock hold, host write port, debug fetch.
module mem_stage_nlane #(
    parameter int NLANE = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 131072,
    parameter int AW    = 17,
    parameter int IW    = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                interlock,
    input  logic [31:0]         pc_in,
    input  logic [IW-1:0]       inst_in,
    input  logic [5*NLANE-1:0]  rt_in,
    input  logic [NLANE-1:0]    req_valid,
    input  logic [NLANE-1:0]    req_we,
    input  logic [32*NLANE-1:0] req_addr,
    input  logic [DW*NLANE-1:0] req_din,
    input  logic [NLANE-1:0]    host_we,
    input  logic [AW*NLANE-1:0] host_addr,
    input  logic [DW*NLANE-1:0] host_din,
    input  logic                fetch_req,
    input  logic [AW-1:0]       fetch_addr,
    output logic [31:0]         pc_out,
    output logic [IW-1:0]       inst_out,
    output logic [5*NLANE-1:0]  rt_out,
    output logic [DW*NLANE-1:0] dout,
    output logic [NLANE-1:0]    dout_valid,
    output logic                fetch_ack,
    output logic [DW-1:0]       fetch_data,
    output logic                oor_err,
    output logic                drop_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;

    logic [DW-1:0] mem [DEPTH];

    logic [31:0]                a_pc;
    logic [IW-1:0]              a_inst;
    logic [5*NLANE-1:0]         a_rt;
    logic [NLANE-1:0]           a_valid;
    logic [NLANE-1:0]           a_we;
    logic [NLANE-1:0][AW-1:0]   a_idx;
    logic [NLANE-1:0][DW-1:0]   a_din;

    logic [NLANE-1:0]           h_we;
    logic [NLANE-1:0][AW-1:0]   h_idx;
    logic [NLANE-1:0][DW-1:0]   h_din;

    logic [1:0]                 f_state;
    logic [AW-1:0]              f_idx;

    logic [NLANE-1:0]           drop;
    logic [NLANE-1:0]           core_wr;
    logic [NLANE-1:0]           core_oor;
    logic [NLANE-1:0]           host_oor;

    function automatic logic in_rng(input logic [AW-1:0] idx);
        return {{(32-AW){1'b0}}, idx} < 32'(DEPTH);
    endfunction

    // Per-lane write enables, store drops and range faults for this edge
    always_comb begin
        drop     = '0;
        core_wr  = '0;
        core_oor = '0;
        host_oor = '0;
        for (int i = 0; i < NLANE; i++) begin
            drop[i]     = host_we[i] & a_valid[i] & a_we[i];
            core_wr[i]  = ~interlock & a_valid[i] & a_we[i]
                        & ~host_we[i] & in_rng(a_idx[i]);
            core_oor[i] = ~interlock & a_valid[i] & ~in_rng(a_idx[i]);
            host_oor[i] = h_we[i] & ~in_rng(h_idx[i]);
        end
    end

    // Stage A: capture lane requests; hold under interlock except drops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_pc    <= '0;
            a_inst  <= '0;
            a_rt    <= '0;
            a_valid <= '0;
            a_we    <= '0;
            a_idx   <= '0;
            a_din   <= '0;
        end else if (interlock) begin
            a_valid <= a_valid & ~drop;
        end else begin
            a_pc    <= pc_in;
            a_inst  <= inst_in;
            a_rt    <= rt_in;
            a_valid <= req_valid;
            a_we    <= req_we;
            for (int i = 0; i < NLANE; i++) begin
                a_idx[i] <= req_addr[32*i+2 +: AW];
                a_din[i] <= req_din[DW*i +: DW];
            end
        end
    end

    // Host port: sample now, write at the following edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_we  <= '0;
            h_idx <= '0;
            h_din <= '0;
        end else begin
            h_we <= host_we;
            for (int i = 0; i < NLANE; i++) begin
                h_idx[i] <= host_addr[AW*i +: AW];
                h_din[i] <= host_din[DW*i +: DW];
            end
        end
    end

    // Array writes: later statements win, so host beats core, high lane beats low
    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANE; i++)
            if (core_wr[i])
                mem[a_idx[i]] <= a_din[i];
        for (int i = 0; i < NLANE; i++)
            if (h_we[i] && in_rng(h_idx[i]))
                mem[h_idx[i]] <= h_din[i];
    end

    // Stage B: read-first array access, sideband and sticky error flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_out     <= '0;
            inst_out   <= '0;
            rt_out     <= '0;
            dout       <= '0;
            dout_valid <= '0;
            oor_err    <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (!interlock) begin
                pc_out     <= a_pc;
                inst_out   <= a_inst;
                rt_out     <= a_rt;
                dout_valid <= a_valid & ~a_we;
                for (int i = 0; i < NLANE; i++)
                    dout[DW*i +: DW] <=
                        (a_valid[i] && !a_we[i] && in_rng(a_idx[i]))
                        ? mem[a_idx[i]] : '0;
            end
            if (|core_oor || |host_oor)
                oor_err <= 1'b1;
            if (|drop)
                drop_err <= 1'b1;
        end
    end

    // Debug fetch FSM, only progresses while the core is interlocked
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            f_state    <= S_IDLE;
            f_idx      <= '0;
            fetch_data <= '0;
        end else begin
            unique case (f_state)
                S_IDLE: begin
                    if (fetch_req && interlock) begin
                        f_idx   <= fetch_addr;
                        f_state <= S_RD;
                    end
                end
                S_RD: begin
                    if (!interlock) begin
                        f_state <= S_IDLE;
                    end else begin
                        fetch_data <= in_rng(f_idx) ? mem[f_idx] : '0;
                        f_state    <= S_RSP;
                    end
                end
                S_RSP:   f_state <= S_IDLE;
                default: f_state <= S_IDLE;
            endcase
        end
    end

    assign fetch_ack = (f_state == S_RSP);

endmodule

// File: tb/tb_mem_stage_nlane.sv
// Scoreboard bench for mem_stage_nlane, 2 lanes, DEPTH=100.
// Stimulus pushes expected bundles; a negedge monitor pops and compares.
module tb_mem_stage_nlane;

    localparam int NL = 2;
    localparam int DW = 32;
    localparam int DP = 100;
    localparam int AW = 7;
    localparam int IW = 64;

    logic            clk;
    logic            rstn;
    logic            interlock;
    logic [31:0]     pc_in;
    logic [IW-1:0]   inst_in;
    logic [5*NL-1:0] rt_in;
    logic [NL-1:0]   req_valid;
    logic [NL-1:0]   req_we;
    logic [32*NL-1:0] req_addr;
    logic [DW*NL-1:0] req_din;
    logic [NL-1:0]   host_we;
    logic [AW*NL-1:0] host_addr;
    logic [DW*NL-1:0] host_din;
    logic            fetch_req;
    logic [AW-1:0]   fetch_addr;
    logic [31:0]     pc_out;
    logic [IW-1:0]   inst_out;
    logic [5*NL-1:0] rt_out;
    logic [DW*NL-1:0] dout;
    logic [NL-1:0]   dout_valid;
    logic            fetch_ack;
    logic [DW-1:0]   fetch_data;
    logic            oor_err;
    logic            drop_err;

    mem_stage_nlane #(
        .NLANE(NL), .DW(DW), .DEPTH(DP), .AW(AW), .IW(IW)
    ) dut (
        .clk(clk), .rstn(rstn), .interlock(interlock),
        .pc_in(pc_in), .inst_in(inst_in), .rt_in(rt_in),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din),
        .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .pc_out(pc_out), .inst_out(inst_out), .rt_out(rt_out),
        .dout(dout), .dout_valid(dout_valid),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .oor_err(oor_err), .drop_err(drop_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  dv;
        logic [31:0] d0;
        logic [31:0] d1;
        int          at;
    } exp_t;

    exp_t        q[$];
    int          checks;
    int          failures;
    int          cyc;
    logic [31:0] last_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] pc, input logic [1:0] v,
                       input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
        pc_in     = pc;
        inst_in   = {pc, ~pc};
        rt_in     = {pc[6:2] + 5'd1, pc[6:2]};
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_din   = {d1, d0};
    endtask

    task automatic idle();
        drv(32'h0, 2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] dv,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int dly);
        q.push_back('{pc, dv, d0, d1, cyc + dly});
    endtask

    // Monitor: each new non-zero pc_out is one retired bundle
    always @(negedge clk) begin
        exp_t e;
        if (pc_out !== last_pc) begin
            last_pc = pc_out;
            if (pc_out !== 32'h0) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bundle actual=%0h required=none",
                             pc_out);
                end else begin
                    e = q.pop_front();
                    chk("pc_out", pc_out, e.pc);
                    chk("dout_valid", dout_valid, e.dv);
                    chk("dout", dout, {e.d1, e.d0});
                    chk("rt_out", rt_out, {e.pc[6:2] + 5'd1, e.pc[6:2]});
                    chk("inst_out", inst_out, {e.pc, ~e.pc});
                    chk("latency_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        logic seen_ack;
        cyc = 0;
        checks = 0;
        failures = 0;
        last_pc = 32'h0;
        rstn = 1'b0;
        interlock = 1'b0;
        host_we = '0;
        host_addr = '0;
        host_din = '0;
        fetch_req = 1'b0;
        fetch_addr = '0;
        idle();
        #3;
        chk("rst_pc_out", pc_out, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_fetch_ack", fetch_ack, 0);
        chk("rst_flags", {oor_err, drop_err}, 0);
        step();
        step();
        rstn = 1'b1;
        step();

        // preload word6=7 and word10=5 through the host port
        host_we   = 2'b11;
        host_addr = {7'd10, 7'd6};
        host_din  = {32'd5, 32'd7};
        step();
        host_we = '0;
        step();

        drv(32'h100, 2'b01, 2'b01, 32'h40, 0, 32'hDEADBEEF, 0);
        push(32'h100, 2'b00, 0, 0, 2);
        step();
        drv(32'h104, 2'b10, 2'b00, 0, 32'h40, 0, 0);
        push(32'h104, 2'b10, 0, 32'hDEADBEEF, 2);
        step();
        drv(32'h108, 2'b11, 2'b11, 32'h14, 32'h14, 32'h1111, 32'h2222);
        push(32'h108, 2'b00, 0, 0, 2);
        step();
        drv(32'h10C, 2'b11, 2'b00, 32'h14, 32'h40, 0, 0);
        push(32'h10C, 2'b11, 32'h2222, 32'hDEADBEEF, 2);
        step();
        drv(32'h110, 2'b11, 2'b01, 32'h18, 32'h18, 32'h99, 0);
        push(32'h110, 2'b10, 0, 32'h7, 2);
        step();
        drv(32'h114, 2'b01, 2'b00, 32'h18, 0, 0, 0);
        push(32'h114, 2'b01, 32'h99, 0, 2);
        step();

        // store word3, then interlock for four cycles
        drv(32'h120, 2'b01, 2'b01, 32'hC, 0, 32'h3333, 0);
        push(32'h120, 2'b00, 0, 0, 6);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            interlock = 1'b1;
            step();
            chk("frozen_pc_out", pc_out, 32'h114);
        end
        interlock = 1'b0;
        drv(32'h124, 2'b10, 2'b00, 0, 32'hC, 0, 0);
        push(32'h124, 2'b10, 0, 32'h3333, 2);
        step();
        idle();
        step();
        step();

        // host write then debug fetch under interlock
        interlock = 1'b1;
        host_we   = 2'b01;
        host_addr = {7'd0, 7'd9};
        host_din  = {32'd0, 32'hCAFE};
        step();
        host_we    = '0;
        fetch_req  = 1'b1;
        fetch_addr = 7'd9;
        step();
        fetch_req = 1'b0;
        chk("fetch_ack_rd", fetch_ack, 0);
        step();
        chk("fetch_ack_rsp", fetch_ack, 1);
        chk("fetch_data", fetch_data, 32'hCAFE);
        step();
        chk("fetch_ack_after", fetch_ack, 0);

        // interlock drops while in RD: no ack
        fetch_req  = 1'b1;
        fetch_addr = 7'd6;
        step();
        fetch_req = 1'b0;
        interlock = 1'b0;
        step();
        chk("abort_ack_1", fetch_ack, 0);
        step();
        chk("abort_ack_2", fetch_ack, 0);
        chk("fetch_data_hold", fetch_data, 32'hCAFE);

        // host write displaces a held core store on lane 0
        chk("drop_err_pre", drop_err, 0);
        drv(32'h130, 2'b01, 2'b01, 32'h28, 0, 32'hAAAA, 0);
        push(32'h130, 2'b00, 0, 0, 4);
        step();
        idle();
        interlock = 1'b1;
        host_we   = 2'b01;
        host_addr = {7'd0, 7'd11};
        host_din  = {32'd0, 32'hBBBB};
        step();
        host_we = '0;
        step();
        interlock = 1'b0;
        drv(32'h134, 2'b11, 2'b00, 32'h28, 32'h2C, 0, 0);
        push(32'h134, 2'b11, 32'h5, 32'hBBBB, 2);
        step();
        idle();
        step();
        chk("drop_err_set", drop_err, 1);

        // out-of-range store and load at word 120
        chk("oor_err_pre", oor_err, 0);
        drv(32'h140, 2'b01, 2'b01, 32'h1E0, 0, 32'h5555, 0);
        push(32'h140, 2'b00, 0, 0, 2);
        step();
        drv(32'h144, 2'b01, 2'b00, 32'h1E0, 0, 0, 0);
        push(32'h144, 2'b01, 0, 0, 2);
        step();
        idle();
        step();
        step();
        chk("oor_err_set", oor_err, 1);

        // reset while fetch is in RD and a load is in flight
        drv(32'h150, 2'b01, 2'b00, 32'h18, 0, 0, 0);
        push(32'h150, 2'b01, 32'h99, 0, 2);
        step();
        drv(32'h154, 2'b10, 2'b00, 0, 32'h18, 0, 0);
        step();
        idle();
        interlock  = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 7'd6;
        step();
        fetch_req = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_pc_out", pc_out, 0);
        chk("arst_dout", {dout_valid, dout}, 0);
        chk("arst_side", {rt_out, inst_out}, 0);
        chk("arst_fetch", {fetch_ack, fetch_data}, 0);
        chk("arst_flags", {oor_err, drop_err}, 0);
        #3;
        rstn = 1'b1;
        seen_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fetch_ack) seen_ack = 1'b1;
            if (i == 1) interlock = 1'b0;
        end
        chk("no_ack_after_reset", seen_ack, 0);
        chk("scoreboard_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
